regfile_multiport: RTL and testbench

- Parametrised successor to the 8x8 register file in the processor datapath.
- Configurable data width and depth; two write ports and two read ports.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Built-in sequential clear engine zeroes the whole file one register per cycle, on request, without a global reset.

---
 rtl/regfile_multiport.sv | 121 ++++++++++++
 tb/tb_regfile_multiport.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Two-write/two-read register file with optional zero register, write bypass and a sweep clear engine.
// Reads are combinational, writes land on the next edge; writes arriving mid-sweep are dropped and flagged.
module regfile_multiport #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [ADDR_W-1:0] raddr_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic [ADDR_W-1:0] raddr_1,
  output logic [DATA_W-1:0] rdata_1,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              busy;
  logic              zero_a;
  logic              zero_b;
  logic              acc_a;
  logic              acc_b;
  logic              drop_nxt;

  assign busy   = (state == ST_CLEAR);
  assign zero_a = (ZERO_REG != 0) && (waddr_a == '0);
  assign zero_b = (ZERO_REG != 0) && (waddr_b == '0);
  assign acc_a  = we_a && !busy && !zero_a;
  assign acc_b  = we_b && !busy && !zero_b;

  // Zero-register writes are discarded silently even mid-sweep, so they never raise wr_drop.
  assign drop_nxt = busy && ((we_a && !zero_a) || (we_b && !zero_b));

  assign clr_busy = busy;
  assign clr_done = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (idx == LAST_IDX) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_drop <= drop_nxt;
      if (state == ST_IDLE && clr_req) begin
        idx <= '0;
      end else if (busy && idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Port B is applied after port A so it wins an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (busy) begin
      mem[idx] <= '0;
    end else begin
      if (acc_a) mem[waddr_a] <= wdata_a;
      if (acc_b) mem[waddr_b] <= wdata_b;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] val;
    val = mem[ra];
    if (BYPASS != 0) begin
      if (acc_b && waddr_b == ra) begin
        val = wdata_b;
      end else if (acc_a && waddr_a == ra) begin
        val = wdata_a;
      end
    end
    if (ZERO_REG != 0 && ra == '0) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rdata_0 = read_port(raddr_0);
  end

  always_comb begin
    rdata_1 = read_port(raddr_1);
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default, no-bypass and zero-register instances share one stimulus.
module tb_regfile_multiport;

  logic       clk;
  logic       rst;
  logic       we_a;
  logic [2:0] waddr_a;
  logic [7:0] wdata_a;
  logic       we_b;
  logic [2:0] waddr_b;
  logic [7:0] wdata_b;
  logic [2:0] raddr_0;
  logic [2:0] raddr_1;
  logic       clr_req;

  logic [7:0] rdata_0, rdata_1;
  logic       clr_busy, clr_done, wr_drop;
  logic [7:0] nb_rdata_0, nb_rdata_1;
  logic       nb_clr_busy, nb_clr_done, nb_wr_drop;
  logic [7:0] zr_rdata_0, zr_rdata_1;
  logic       zr_clr_busy, zr_clr_done, zr_wr_drop;

  int checks = 0;
  int errors = 0;

  regfile_multiport u_dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_0(raddr_0), .rdata_0(rdata_0),
    .raddr_1(raddr_1), .rdata_1(rdata_1),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  regfile_multiport #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_0(raddr_0), .rdata_0(nb_rdata_0),
    .raddr_1(raddr_1), .rdata_1(nb_rdata_1),
    .clr_req(clr_req), .clr_busy(nb_clr_busy), .clr_done(nb_clr_done), .wr_drop(nb_wr_drop)
  );

  regfile_multiport #(.ZERO_REG(1)) u_zr (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_0(raddr_0), .rdata_0(zr_rdata_0),
    .raddr_1(raddr_1), .rdata_1(zr_rdata_1),
    .clr_req(clr_req), .clr_busy(zr_clr_busy), .clr_done(zr_clr_done), .wr_drop(zr_wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      we_a = 1'b1; waddr_a = 3'(a); wdata_a = 8'hFF;
      we_b = 1'b1; waddr_b = 3'(a); wdata_b = 8'hFF;
      tick();
    end
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b drop=%b, expected 0 0 0", clr_busy, clr_done, wr_drop);
    end
    we_a = 1'b0; we_b = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      raddr_0 = 3'(a); raddr_1 = 3'(7 - a);
      #1;
      checks++;
      if (rdata_0 !== 8'h00 || rdata_1 !== 8'h00) begin
        errors++;
        $display("FAIL reset_read[%0d]: rdata_0=%h rdata_1=%h, expected 00 00", a, rdata_0, rdata_1);
      end
    end
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_flags: busy=%b done=%b drop=%b, expected 0 0 0", clr_busy, clr_done, wr_drop);
    end
  endtask

  task automatic test_collision;
    we_a = 1'b1; waddr_a = 3'd3; wdata_a = 8'h11;
    we_b = 1'b1; waddr_b = 3'd3; wdata_b = 8'h22;
    tick();
    we_a = 1'b0; we_b = 1'b0; raddr_0 = 3'd3;
    #1;
    checks++;
    if (rdata_0 !== 8'h22) begin
      errors++;
      $display("FAIL collision: rdata_0=%h, expected 22", rdata_0);
    end
    tick();
    we_a = 1'b1; waddr_a = 3'd2; wdata_a = 8'h33;
    we_b = 1'b1; waddr_b = 3'd5; wdata_b = 8'h44;
    tick();
    we_a = 1'b0; we_b = 1'b0; raddr_0 = 3'd2; raddr_1 = 3'd5;
    #1;
    checks++;
    if (rdata_0 !== 8'h33 || rdata_1 !== 8'h44) begin
      errors++;
      $display("FAIL dual_write: rdata_0=%h rdata_1=%h, expected 33 44", rdata_0, rdata_1);
    end
  endtask

  task automatic test_bypass;
    we_a = 1'b1; waddr_a = 3'd4; wdata_a = 8'h10;
    tick();
    wdata_a = 8'h5A; raddr_1 = 3'd4;
    #1;
    checks++;
    if (rdata_1 !== 8'h5A) begin
      errors++;
      $display("FAIL bypass_on: rdata_1=%h, expected 5a", rdata_1);
    end
    checks++;
    if (nb_rdata_1 !== 8'h10) begin
      errors++;
      $display("FAIL bypass_off_same: rdata_1=%h, expected 10", nb_rdata_1);
    end
    tick();
    we_a = 1'b0;
    #1;
    checks++;
    if (nb_rdata_1 !== 8'h5A || rdata_1 !== 8'h5A) begin
      errors++;
      $display("FAIL bypass_next: nobyp=%h byp=%h, expected 5a 5a", nb_rdata_1, rdata_1);
    end
  endtask

  task automatic test_zero_reg;
    we_a = 1'b1; waddr_a = 3'd0; wdata_a = 8'hAA; raddr_0 = 3'd0;
    #1;
    checks++;
    if (zr_rdata_0 !== 8'h00) begin
      errors++;
      $display("FAIL zero_reg_bypass: rdata_0=%h, expected 00", zr_rdata_0);
    end
    checks++;
    if (rdata_0 !== 8'hAA) begin
      errors++;
      $display("FAIL reg0_bypass_default: rdata_0=%h, expected aa", rdata_0);
    end
    tick();
    we_a = 1'b0;
    #1;
    checks++;
    if (zr_rdata_0 !== 8'h00 || zr_wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg_store: rdata_0=%h wr_drop=%b, expected 00 0", zr_rdata_0, zr_wr_drop);
    end
    checks++;
    if (rdata_0 !== 8'hAA) begin
      errors++;
      $display("FAIL reg0_store_default: rdata_0=%h, expected aa", rdata_0);
    end
  endtask

  task automatic test_sweep;
    for (int k = 0; k < 8; k++) begin
      we_a = 1'b1; waddr_a = 3'(k); wdata_a = 8'(k + 1);
      tick();
    end
    we_a = 1'b0; clr_req = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      clr_req = (c == 3);
      raddr_0 = 3'(c);
      raddr_1 = (c == 0) ? 3'd0 : 3'(c - 1);
      #1;
      checks++;
      if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin
        errors++;
        $display("FAIL sweep_busy[%0d]: busy=%b done=%b, expected 1 0", c, clr_busy, clr_done);
      end
      checks++;
      if (rdata_0 !== 8'(c + 1)) begin
        errors++;
        $display("FAIL sweep_pending[%0d]: rdata_0=%h, expected %h", c, rdata_0, 8'(c + 1));
      end
      if (c > 0) begin
        checks++;
        if (rdata_1 !== 8'h00) begin
          errors++;
          $display("FAIL sweep_cleared[%0d]: rdata_1=%h, expected 00", c, rdata_1);
        end
      end
      tick();
    end
    clr_req = 1'b0; raddr_0 = 3'd7;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b1 || rdata_0 !== 8'h00) begin
      errors++;
      $display("FAIL sweep_done: busy=%b done=%b reg7=%h, expected 0 1 00", clr_busy, clr_done, rdata_0);
    end
    tick();
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL sweep_idle: busy=%b done=%b, expected 0 0", clr_busy, clr_done);
    end
  endtask

  task automatic test_write_during_clear;
    logic seen;
    seen = 1'b0;
    we_a = 1'b1; waddr_a = 3'd6; wdata_a = 8'h66;
    tick();
    we_a = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    we_a = 1'b1; waddr_a = 3'd6; wdata_a = 8'h77;
    we_b = 1'b1; waddr_b = 3'd0; wdata_b = 8'h77;
    raddr_0 = 3'd0; raddr_1 = 3'd6;
    #1;
    checks++;
    if (rdata_1 !== 8'h66 || rdata_0 !== 8'h00) begin
      errors++;
      $display("FAIL busy_read_no_bypass: reg6=%h reg0=%h, expected 66 00", rdata_1, rdata_0);
    end
    checks++;
    if (wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_early: wr_drop=%b, expected 0", wr_drop);
    end
    tick();
    we_a = 1'b0; we_b = 1'b0;
    checks++;
    if (wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: wr_drop=%b, expected 1", wr_drop);
    end
    tick();
    checks++;
    if (wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_width: wr_drop=%b, expected 0", wr_drop);
    end
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (clr_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL drop_sweep_done: clr_done never seen within 12 cycles, expected a pulse");
    end
    tick();
    #1;
    checks++;
    if (rdata_0 !== 8'h00 || rdata_1 !== 8'h00) begin
      errors++;
      $display("FAIL dropped_writes: reg0=%h reg6=%h, expected 00 00", rdata_0, rdata_1);
    end
  endtask

  task automatic test_reset_mid_sweep;
    logic seen;
    seen = 1'b0;
    we_a = 1'b1; waddr_a = 3'd5; wdata_a = 8'h55;
    we_b = 1'b1; waddr_b = 3'd7; wdata_b = 8'h99;
    tick();
    we_a = 1'b0; we_b = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    tick();
    raddr_0 = 3'd5; raddr_1 = 3'd7;
    #1;
    checks++;
    if (clr_busy !== 1'b1 || rdata_0 !== 8'h55) begin
      errors++;
      $display("FAIL pre_abort: busy=%b reg5=%h, expected 1 55", clr_busy, rdata_0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || rdata_0 !== 8'h00 || rdata_1 !== 8'h00) begin
      errors++;
      $display("FAIL abort_immediate: busy=%b done=%b reg5=%h reg7=%h, expected 0 0 00 00",
               clr_busy, clr_done, rdata_0, rdata_1);
    end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: clr_done/clr_busy rose after aborted sweep, expected both 0");
    end
    checks++;
    if (rdata_0 !== 8'h00 || rdata_1 !== 8'h00) begin
      errors++;
      $display("FAIL abort_contents: reg5=%h reg7=%h, expected 00 00", rdata_0, rdata_1);
    end
  endtask

  initial begin
    rst = 1'b0;
    we_a = 1'b0; waddr_a = '0; wdata_a = '0;
    we_b = 1'b0; waddr_b = '0; wdata_b = '0;
    raddr_0 = '0; raddr_1 = '0; clr_req = 1'b0;
    #2;
    test_reset();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_sweep();
    test_write_during_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
